stop_frame_check: RTL and testbench
===================================

Name: stop_frame_check

Overview:
- Parametrised stop-bit checker for the UART receive path; generalises single-bit stop checking to a runtime-selectable count of 1..MAX_STOP stop bits per frame.
- Accumulates a per-frame stop error and pulses a frame-done strobe.
- Keeps a saturating error counter and a sticky error flag for status readout.
- Driven by the RX FSM, which issues one enable strobe per stop-bit sample point.

Parameters:
- MAX_STOP, 2, maximum stop bits per frame (>=1).
- CNT_W, 8, width of saturating stop-error counter.
- Derived localparam CFG_W = $clog2(MAX_STOP+1), width of stop_bits_cfg.

Ports:
- clk_stpc  input  1  clock.
- rst_stpc  input  1  reset, asynchronous, active-low.
- stop_check_en_stpc  input  1  one-cycle strobe; sampled_bit_stpc is a stop-bit sample this cycle.
- sampled_bit_stpc  input  1  sampled line value.
- stop_bits_cfg  input  CFG_W  stop bits per frame; latched at first strobe of a frame.
- frame_abort  input  1  RX FSM abandons the frame; return to idle.
- err_clr  input  1  clears err_count and err_sticky.
- stop_error_stpc  output  1  result of last completed frame (1 = any stop bit sampled 0).
- stop_done  output  1  one-cycle pulse; frame's stop bits fully checked.
- stop_bit_idx  output  CFG_W  index of next expected stop bit; 0 in IDLE.
- err_count  output  CNT_W  saturating count of frames with stop error.
- err_sticky  output  1  set on any stop error, held until err_clr.

Behaviour:
- Reset (rst_stpc low, async): state IDLE, all outputs 0, internal accumulator 0, latched cfg 0.
- Effective count n = stop_bits_cfg clamped: 0 -> 1, >MAX_STOP -> MAX_STOP.
- IDLE, strobe, no abort: latch n; acc = ~sampled_bit_stpc.
  - n==1: complete frame at this edge.
  - otherwise: go to CHECK, stop_bit_idx = 1.
- CHECK, strobe, no abort: acc |= ~sampled_bit_stpc; stop_bit_idx++.
  - Completes when stop_bit_idx == n-1 at the strobe; then return to IDLE, stop_bit_idx = 0.
- CHECK, no strobe: hold all state; no timeout.
- Completion, registered at the strobe edge and visible the next cycle:
  - stop_done = 1 for exactly one cycle.
  - stop_error_stpc = final acc.
  - If acc: err_count++ (saturates at 2^CNT_W-1, no wrap) and err_sticky = 1.
- Latency: last stop-bit strobe -> stop_done/stop_error_stpc valid = 1 cycle.
- stop_error_stpc holds its value between completions; never updated mid-frame.
- frame_abort:
  - In any state: next state IDLE, stop_bit_idx = 0, acc = 0.
  - No stop_done, no stop_error_stpc, count or sticky update.
  - Abort wins over a simultaneous strobe.
- stop_bits_cfg changes mid-frame: ignored until the next frame.
- err_clr alone: err_count = 0, err_sticky = 0 next cycle.
- err_clr on the same edge as an erroring completion: err_count = 1, err_sticky = 1; the new error is never lost.
- err_clr on the same edge as a clean completion: count 0, sticky 0.
- Back-to-back frames: a strobe on the cycle stop_done is high starts a new frame from IDLE normally.

Optional Feature:
- Macro STOP_BREAK_DET_EN.
- Defined: adds input data_all_zero_stpc (1 = current frame's data bits all 0, valid from first stop strobe to completion) and output break_det_stpc.
  - break_det_stpc pulses one cycle, coincident with stop_done, when data_all_zero_stpc is 1 and every stop bit sampled 0.
  - A break frame still sets stop_error_stpc and counts as an error.
  - Reset value 0.
- Undefined: port and logic absent; otherwise identical behaviour.

Test Plan:
- Reset mid-CHECK (cfg=2, one strobe with bit=1, then rst_stpc low) -> all outputs 0, state IDLE; the next single strobe does not complete the frame.
- cfg=1, strobe bit=1 then a frame with strobe bit=0 -> stop_done pulses each one cycle after the strobe; stop_error_stpc 0 then 1; err_count 1; err_sticky 1.
- cfg=2, strobes bit=1 then bit=0 with 3 idle cycles between -> single stop_done after the second strobe; stop_error_stpc=1; stop_bit_idx 0,1,0.
- cfg=2, first strobe bit=0 then frame_abort -> no stop_done; err_count unchanged; the next cfg=2 frame with bits 1,1 gives stop_error_stpc=0.
- CNT_W=2, 5 erroring frames, then err_clr coincident with a 6th erroring completion -> err_count 1,2,3,3,3, then 1; err_sticky stays 1.
- STOP_BREAK_DET_EN, cfg=1, data_all_zero_stpc=1, strobe bit=0 -> break_det_stpc and stop_done high together for one cycle, stop_error_stpc=1; with bit=1 -> no break_det_stpc.

Source files
------------

// File: rtl/stop_frame_check_if.sv
// Bundle between the RX FSM and the stop-bit checker.
// The RX FSM drives through the master modport and the checker receives through the slave modport.
// When STOP_BREAK_DET_EN is defined, the bundle also carries the break-detect signals.
interface stop_frame_check_if #(
   parameter int MAX_STOP = 2,
   parameter int CNT_W    = 8
);
   localparam int CFG_W = $clog2(MAX_STOP + 1);

   logic             stop_check_en_stpc;
   logic             sampled_bit_stpc;
   logic [CFG_W-1:0] stop_bits_cfg;
   logic             frame_abort;
   logic             err_clr;
   logic             stop_error_stpc;
   logic             stop_done;
   logic [CFG_W-1:0] stop_bit_idx;
   logic [CNT_W-1:0] err_count;
   logic             err_sticky;
`ifdef STOP_BREAK_DET_EN
   logic             data_all_zero_stpc;
   logic             break_det_stpc;
`endif

   modport master (
      output stop_check_en_stpc, sampled_bit_stpc, stop_bits_cfg, frame_abort, err_clr,
`ifdef STOP_BREAK_DET_EN
      output data_all_zero_stpc,
      input  break_det_stpc,
`endif
      input  stop_error_stpc, stop_done, stop_bit_idx, err_count, err_sticky
   );

   modport slave (
      input  stop_check_en_stpc, sampled_bit_stpc, stop_bits_cfg, frame_abort, err_clr,
`ifdef STOP_BREAK_DET_EN
      input  data_all_zero_stpc,
      output break_det_stpc,
`endif
      output stop_error_stpc, stop_done, stop_bit_idx, err_count, err_sticky
   );
endinterface

// File: rtl/stop_frame_check.sv
// Stop-bit checker for the UART receive path.
// It checks 1..MAX_STOP stop bits per frame. The stop-bit count is chosen at runtime and latched at
// the first stop strobe of each frame. When the frame completes, the checker reports one stop error
// for the whole frame and pulses a done strobe. It also keeps a saturating error counter and a
// sticky error flag for status readout.
// Optional feature macro: STOP_BREAK_DET_EN. When it is defined, the checker flags a break frame:
// every data bit is 0 and every stop bit is 0.
module stop_frame_check #(
   parameter int MAX_STOP = 2,
   parameter int CNT_W    = 8
) (
   input logic               clk_stpc,
   input logic               rst_stpc,
   stop_frame_check_if.slave bus
);
   localparam int CFG_W = $clog2(MAX_STOP + 1);

   typedef enum logic {
      IDLE,
      CHECK
   } state_t;

   state_t           state;
   logic [CFG_W-1:0] n_lat;      // stop bits expected in the current frame
   logic             acc;        // any stop bit of this frame sampled 0
   logic [CFG_W-1:0] n_eff;      // clamped stop_bits_cfg
   logic             strobe;     // strobe that is not overridden by an abort
   logic             complete;   // this strobe finishes the frame
   logic             fin_err;    // frame error including this strobe's sample
`ifdef STOP_BREAK_DET_EN
   logic             all_zero;   // every stop bit so far sampled 0
   logic             fin_zero;
`endif

   // Clamp the requested stop-bit count into 1..MAX_STOP.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      n_eff = bus.stop_bits_cfg;
      if (bus.stop_bits_cfg == '0)
         n_eff = CFG_W'(1);
      else if (bus.stop_bits_cfg > CFG_W'(MAX_STOP))
         n_eff = CFG_W'(MAX_STOP);
   end

   // Decide whether this cycle's strobe completes the frame, and fold in its sample.
   always_comb begin
      strobe   = bus.stop_check_en_stpc && !bus.frame_abort;
      complete = 1'b0;
      fin_err  = 1'b0;
`ifdef STOP_BREAK_DET_EN
      fin_zero = 1'b0;
`endif
      if (strobe) begin
         if (state == IDLE) begin
            complete = (n_eff == CFG_W'(1));
            fin_err  = ~bus.sampled_bit_stpc;
`ifdef STOP_BREAK_DET_EN
            fin_zero = ~bus.sampled_bit_stpc;
`endif
         end else begin
            complete = (bus.stop_bit_idx == n_lat - CFG_W'(1));
            fin_err  = acc | ~bus.sampled_bit_stpc;
`ifdef STOP_BREAK_DET_EN
            fin_zero = all_zero & ~bus.sampled_bit_stpc;
`endif
         end
      end
   end

   // Frame FSM. It steps through the stop bits and registers the per-frame result and the done pulse.
   // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_stpc or negedge rst_stpc) begin
      if (!rst_stpc) begin
         state               <= IDLE;
         n_lat               <= '0;
         acc                 <= 1'b0;
         bus.stop_bit_idx    <= '0;
         bus.stop_done       <= 1'b0;
         bus.stop_error_stpc <= 1'b0;
`ifdef STOP_BREAK_DET_EN
         all_zero            <= 1'b0;
         bus.break_det_stpc  <= 1'b0;
`endif
      end else begin
         bus.stop_done <= 1'b0;
`ifdef STOP_BREAK_DET_EN
         bus.break_det_stpc <= 1'b0;
`endif
         if (bus.frame_abort) begin
            state            <= IDLE;
            acc              <= 1'b0;
            bus.stop_bit_idx <= '0;
`ifdef STOP_BREAK_DET_EN
            all_zero         <= 1'b0;
`endif
         end else if (strobe) begin
            if (state == IDLE)
               n_lat <= n_eff;
            if (complete) begin
               state               <= IDLE;
               acc                 <= 1'b0;
               bus.stop_bit_idx    <= '0;
               bus.stop_done       <= 1'b1;
               bus.stop_error_stpc <= fin_err;
`ifdef STOP_BREAK_DET_EN
               all_zero            <= 1'b0;
               bus.break_det_stpc  <= fin_zero & bus.data_all_zero_stpc;
`endif
            end else begin
               state            <= CHECK;
               acc              <= fin_err;
               bus.stop_bit_idx <= bus.stop_bit_idx + CFG_W'(1);
`ifdef STOP_BREAK_DET_EN
               all_zero         <= fin_zero;
`endif
            end
         end
      end
   end

   // Status counters. A clear never discards an error that completes on the same edge.
   always_ff @(posedge clk_stpc or negedge rst_stpc) begin
      if (!rst_stpc) begin
         bus.err_count  <= '0;
         bus.err_sticky <= 1'b0;
      end else if (bus.err_clr) begin
         bus.err_count  <= (complete && fin_err) ? CNT_W'(1) : '0;
         bus.err_sticky <= complete && fin_err;
      end else if (complete && fin_err) begin
         if (bus.err_count != {CNT_W{1'b1}})
            bus.err_count <= bus.err_count + CNT_W'(1);
         bus.err_sticky <= 1'b1;
      end
   end
endmodule

// File: tb/tb_stop_frame_check.sv
// Self-checking bench for stop_frame_check (MAX_STOP=2, CNT_W=2).
// A frame-level model collects the stop samples of each frame in a queue. It decides completion,
// error and break from the collected samples. A compare process checks the DUT against the model on
// every falling edge. Directed scenarios add literal expectations, and a randomized run follows.
module tb_stop_frame_check;
   localparam int MAX_STOP = 2;
   localparam int CNT_W    = 2;
   localparam int CFG_W    = $clog2(MAX_STOP + 1);
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic clk_stpc = 1'b0;
   logic rst_stpc = 1'b0;
   always #5 clk_stpc = ~clk_stpc;

   stop_frame_check_if #(.MAX_STOP(MAX_STOP), .CNT_W(CNT_W)) bus ();

   stop_frame_check #(.MAX_STOP(MAX_STOP), .CNT_W(CNT_W)) dut (
      .clk_stpc (clk_stpc),
      .rst_stpc (rst_stpc),
      .bus      (bus)
   );

   int total = 0;
   int bad   = 0;

   // Frame-level reference model.
   bit m_busy;
   int m_n;
   bit m_bits[$];
   int e_done, e_err, e_idx, e_cnt, e_sticky, e_brk;
   bit chk_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clamp_cfg(input int cfg);
      if (cfg == 0) return 1;
      if (cfg > MAX_STOP) return MAX_STOP;
      return cfg;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_n = 0; m_bits.delete();
      e_done = 0; e_err = 0; e_idx = 0; e_cnt = 0; e_sticky = 0; e_brk = 0;
   endtask

   task automatic model_step(input bit en, input bit sb, input int cfg, input bit abort,
                             input bit clr, input bit daz);
      bit done_now, err_now, all0;
      done_now = 0; err_now = 0; all0 = 1;
      e_done = 0; e_brk = 0;
      if (abort) begin
         m_busy = 0; m_bits.delete();
      end else if (en) begin
         if (!m_busy) begin m_n = clamp_cfg(cfg); m_busy = 1; end
         m_bits.push_back(sb);
         if (m_bits.size() == m_n) begin
            foreach (m_bits[i]) begin
               if (m_bits[i] == 1'b0) err_now = 1;
               else all0 = 0;
            end
            done_now = 1;
            e_done = 1; e_err = err_now;
            e_brk = daz && all0;
            m_busy = 0; m_bits.delete();
         end
      end
      if (clr) begin
         e_cnt = (done_now && err_now) ? 1 : 0;
         e_sticky = (done_now && err_now) ? 1 : 0;
      end else if (done_now && err_now) begin
         if (e_cnt < CNT_MAX) e_cnt++;
         e_sticky = 1;
      end
      e_idx = m_busy ? m_bits.size() : 0;
   endtask

   // Apply one cycle of inputs, advance the model at the edge, and return at the next falling edge.
   task automatic step(input bit en, input bit sb, input int cfg, input bit abort = 0,
                       input bit clr = 0, input bit daz = 0);
      bus.stop_check_en_stpc = en;
      bus.sampled_bit_stpc   = sb;
      bus.stop_bits_cfg      = CFG_W'(cfg);
      bus.frame_abort        = abort;
      bus.err_clr            = clr;
`ifdef STOP_BREAK_DET_EN
      bus.data_all_zero_stpc = daz;
`endif
      @(posedge clk_stpc);
      model_step(en, sb, cfg, abort, clr, daz);
      @(negedge clk_stpc);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 1, 0);
   endtask

   // Compare the DUT with the model on every falling edge once the bench is out of reset.
   always @(negedge clk_stpc) begin
      if (chk_en && rst_stpc) begin
         check("cmp_done",   int'(bus.stop_done),       e_done);
         check("cmp_err",    int'(bus.stop_error_stpc), e_err);
         check("cmp_idx",    int'(bus.stop_bit_idx),    e_idx);
         check("cmp_cnt",    int'(bus.err_count),       e_cnt);
         check("cmp_sticky", int'(bus.err_sticky),      e_sticky);
`ifdef STOP_BREAK_DET_EN
         check("cmp_brk",    int'(bus.break_det_stpc),  e_brk);
`endif
      end
   end

   initial begin
      bus.stop_check_en_stpc = 0;
      bus.sampled_bit_stpc   = 1;
      bus.stop_bits_cfg      = '0;
      bus.frame_abort        = 0;
      bus.err_clr            = 0;
`ifdef STOP_BREAK_DET_EN
      bus.data_all_zero_stpc = 0;
`endif
      model_reset();
      repeat (2) @(negedge clk_stpc);
      check("rst_done",   int'(bus.stop_done),       0);
      check("rst_err",    int'(bus.stop_error_stpc), 0);
      check("rst_idx",    int'(bus.stop_bit_idx),    0);
      check("rst_cnt",    int'(bus.err_count),       0);
      check("rst_sticky", int'(bus.err_sticky),      0);
      rst_stpc = 1;
      chk_en = 1;
      idle(2);

      // Assert reset in the middle of a 2-stop-bit frame.
      step(1, 1, 2);
      check("mid_idx1", int'(bus.stop_bit_idx), 1);
      #2 rst_stpc = 0;
      model_reset();
      #1;
      check("arst_idx",  int'(bus.stop_bit_idx), 0);
      check("arst_done", int'(bus.stop_done),    0);
      @(negedge clk_stpc);
      rst_stpc = 1;
      step(1, 0, 2);
      check("post_rst_nodone", int'(bus.stop_done),    0);
      check("post_rst_idx",    int'(bus.stop_bit_idx), 1);
      step(0, 1, 2, 1);

      // Single stop bit: one clean frame, then one erroring frame.
      step(1, 1, 1);
      check("s1_done", int'(bus.stop_done),       1);
      check("s1_err",  int'(bus.stop_error_stpc), 0);
      step(0, 1, 1);
      check("s1_pulse", int'(bus.stop_done), 0);
      step(1, 0, 1);
      check("s2_err",    int'(bus.stop_error_stpc), 1);
      check("s2_cnt",    int'(bus.err_count),       1);
      check("s2_sticky", int'(bus.err_sticky),      1);
      step(0, 1, 0, 0, 1);
      check("clr_cnt",    int'(bus.err_count),  0);
      check("clr_sticky", int'(bus.err_sticky), 0);

      // Two stop bits with idle gaps between them; the second bit is bad.
      step(1, 1, 2);
      check("g_idx1", int'(bus.stop_bit_idx), 1);
      idle(3);
      check("g_hold", int'(bus.stop_bit_idx), 1);
      step(1, 0, 2);
      check("g_done", int'(bus.stop_done),       1);
      check("g_err",  int'(bus.stop_error_stpc), 1);
      check("g_idx0", int'(bus.stop_bit_idx),    0);

      // Abort after a bad first bit, then a clean frame.
      step(1, 0, 2);
      step(0, 1, 2, 1);
      check("ab_nodone", int'(bus.stop_done), 0);
      check("ab_cnt",    int'(bus.err_count), 1);
      step(1, 1, 2);
      step(1, 1, 2);
      check("ab_next_err", int'(bus.stop_error_stpc), 0);

      // Counter saturation, then a clear on the same edge as an error.
      step(0, 1, 1, 0, 1);
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 1);
         check("sat_cnt", int'(bus.err_count), (i < 3) ? i + 1 : 3);
      end
      step(1, 0, 1, 0, 1);
      check("clr_err_cnt",    int'(bus.err_count),  1);
      check("clr_err_sticky", int'(bus.err_sticky), 1);

      // Clamping: cfg 3 behaves as 2 stop bits, and cfg 0 behaves as 1 stop bit.
      step(1, 1, 3);
      check("cl3_nodone", int'(bus.stop_done), 0);
      step(1, 1, 0);
      check("cl3_done", int'(bus.stop_done), 1);
      step(1, 1, 0);
      check("cl0_done", int'(bus.stop_done), 1);

`ifdef STOP_BREAK_DET_EN
      step(1, 0, 1, 0, 0, 1);
      check("brk_hi",  int'(bus.break_det_stpc), 1);
      check("brk_err", int'(bus.stop_error_stpc), 1);
      step(1, 1, 1, 0, 0, 1);
      check("brk_lo",  int'(bus.break_det_stpc), 0);
`endif

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 3),
              $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 1));
      end

      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
